network_mac_pipe_mul_acc: RTL

Parametrised, pipelined signed×unsigned multiply-accumulate unit. Next generation of the single-cycle network_mul_* multipliers used by the conv/dense layers.
Multiplies a signed activation by an unsigned weight and accumulates a packet of products (one kernel dot product). Emits one fixed-point, saturated result per packet over a valid/ready stream.
Sits between the line-buffer/weight-ROM readers and the activation stage.

---
 rtl/network_mac_pipe_mul_acc_if.sv | 27 ++
 rtl/network_mac_pipe_mul_acc.sv | 125 ++++++++++++
 2 files changed

// File: rtl/network_mac_pipe_mul_acc_if.sv
// Stream bundle for network_mac_pipe_mul_acc: operand beats in, saturated
// results out, each side with its own valid/ready pair.
interface network_mac_pipe_mul_acc_if #(
    parameter int DIN0_WIDTH = 16,
    parameter int DIN1_WIDTH = 12,
    parameter int DOUT_WIDTH = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DIN0_WIDTH-1:0] din0;
    logic [DIN1_WIDTH-1:0] din1;
    logic                  in_last;
    logic                  out_valid;
    logic                  out_ready;
    logic [DOUT_WIDTH-1:0] dout;
    logic                  dout_sat;

    modport master (
        output in_valid, din0, din1, in_last, out_ready,
        input  in_ready, out_valid, dout, dout_sat
    );

    modport slave (
        input  in_valid, din0, din1, in_last, out_ready,
        output in_ready, out_valid, dout, dout_sat
    );
endinterface

// File: rtl/network_mac_pipe_mul_acc.sv
// Pipelined signed x unsigned multiply-accumulate. Products of one packet
// (beats up to in_last) are summed, then shifted right by FRAC_SHIFT and
// saturated to DOUT_WIDTH. The whole pipe advances together unless ce is low
// or a finished result is waiting on downstream.
// Optional build macro NETWORK_MAC_PIPE_ROUND_EN: round-half-up before the
// shift instead of plain truncation toward -inf.
module network_mac_pipe_mul_acc #(
    parameter int DIN0_WIDTH = 16,
    parameter int DIN1_WIDTH = 12,
    parameter int ACC_WIDTH  = 40,
    parameter int DOUT_WIDTH = 16,
    parameter int FRAC_SHIFT = 10,
    parameter int NUM_STAGE  = 3
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst,
    input  logic                        ce,
    network_mac_pipe_mul_acc_if.slave   s,
    output logic                        busy
);
    localparam int PW = DIN0_WIDTH + DIN1_WIDTH;

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-DOUT_WIDTH+1){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-DOUT_WIDTH+1){1'b1}}, {(DOUT_WIDTH-1){1'b0}}};
    // (1 << F) >> 1 gives 2^(F-1), and collapses to 0 when F is 0.
    localparam logic signed [ACC_WIDTH-1:0] RND_ADD =
        ({{(ACC_WIDTH-1){1'b0}}, 1'b1} << FRAC_SHIFT) >> 1;

    logic                           stall;
    logic signed [PW-1:0]           mul_a, mul_b, prod;
    logic [NUM_STAGE-1:0][PW-1:0]   prod_q;
    logic [NUM_STAGE-1:0]           vld_q, last_q;
    logic signed [PW-1:0]           p_tail;
    logic                           vld_tail, last_tail;
    logic signed [ACC_WIDTH-1:0]    acc_q, p_ext, acc_new, acc_rnd, acc_sh;
    logic                           first_q;
    logic                           out_valid_q, dout_sat_q, dout_sat_d;
    logic [DOUT_WIDTH-1:0]          dout_q, dout_d;

    assign stall      = !ce || (out_valid_q && !s.out_ready);
    assign s.in_ready = !stall;

    // Widen both operands to the exact product width; din1 is zero-extended,
    // so the product can never overflow PW bits.
    assign mul_a = {{DIN1_WIDTH{s.din0[DIN0_WIDTH-1]}}, s.din0};
    assign mul_b = {{DIN0_WIDTH{1'b0}}, s.din1};
    assign prod  = mul_a * mul_b;

    // Multiplier pipe: product, valid and last travel together.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            prod_q <= '0;
            vld_q  <= '0;
            last_q <= '0;
        end else if (!stall) begin
            prod_q[0] <= prod;
            vld_q[0]  <= s.in_valid;
            last_q[0] <= s.in_last;
            for (int k = 1; k < NUM_STAGE; k++) begin
                prod_q[k] <= prod_q[k-1];
                vld_q[k]  <= vld_q[k-1];
                last_q[k] <= last_q[k-1];
            end
        end
    end

    assign p_tail    = prod_q[NUM_STAGE-1];
    assign vld_tail  = vld_q[NUM_STAGE-1];
    assign last_tail = last_q[NUM_STAGE-1];

    // Accumulate, optionally round, shift and clip the packet result.
    always_comb begin
        p_ext      = {{(ACC_WIDTH-PW){p_tail[PW-1]}}, p_tail};
        acc_new    = first_q ? p_ext : acc_q + p_ext;
`ifdef NETWORK_MAC_PIPE_ROUND_EN
        acc_rnd    = acc_new + RND_ADD;
`else
        acc_rnd    = acc_new;
`endif
        acc_sh     = acc_rnd >>> FRAC_SHIFT;
        dout_d     = acc_sh[DOUT_WIDTH-1:0];
        dout_sat_d = 1'b0;
        if (acc_sh > SAT_MAX) begin
            dout_d     = SAT_MAX[DOUT_WIDTH-1:0];
            dout_sat_d = 1'b1;
        end else if (acc_sh < SAT_MIN) begin
            dout_d     = SAT_MIN[DOUT_WIDTH-1:0];
            dout_sat_d = 1'b1;
        end
    end

    // Accumulator state; the first flag re-arms after each last beat.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            acc_q   <= '0;
            first_q <= 1'b1;
        end else if (!stall && vld_tail) begin
            acc_q   <= acc_new;
            first_q <= last_tail;
        end
    end

    // Result register: when not stalled, either out_valid was 0 or it is
    // being drained this cycle, so loading a new result needs no bubble.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            out_valid_q <= 1'b0;
            dout_q      <= '0;
            dout_sat_q  <= 1'b0;
        end else if (!stall) begin
            out_valid_q <= vld_tail && last_tail;
            if (vld_tail && last_tail) begin
                dout_q     <= dout_d;
                dout_sat_q <= dout_sat_d;
            end
        end
    end

    assign s.out_valid = out_valid_q;
    assign s.dout      = dout_q;
    assign s.dout_sat  = dout_sat_q;
    assign busy        = (|vld_q) || !first_q;
endmodule
